decode_hazard_scoreboard: RTL and testbench
===========================================

# decode_hazard_scoreboard

Per-register scoreboard and stall controller that sequences issue out of the instruction-decode stage of the 5-stage MIPS pipeline. It tracks how many cycles remain until each in-flight destination register's result can be consumed (by forwarding or writeback). It holds the decode stage while an operand is not yet consumable, and grants issue into EX otherwise. It sits beside the decode/register-file block and drives the IF/ID hold and the ID/EX bubble insertion.

## Interface
- ALU_LAT, 0: cycles after issue before an ALU result is consumable; 0 = fully forwarded, never stalls.
- LOAD_LAT, 1: cycles after issue before a load result is consumable; the load-use bubble.
- CNT_W, 2: width of each per-register countdown; ALU_LAT and LOAD_LAT must be ≤ 2^CNT_W−1.
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs_addr  in  5  source register rs (instruction[25:21]).
- id_rt_addr  in  5  source register rt (instruction[20:16]).
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_dest_addr  in  5  destination register (rd or rt per opcode).
- id_dest_we  in  1  instruction writes id_dest_addr.
- id_is_load  in  1  instruction is a load (op 0x23).
- wb_we  in  1  writeback commits this cycle.
- wb_addr  in  5  writeback destination.
- flush  in  1  branch/jump resolved taken; kill decode instruction.
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational).
- issue  out  1  decode instruction advances into EX this cycle (combinational).
- busy_mask  out  32  bit i set when cnt[i] ≠ 0; bit 0 always 0.
- stall_cycles  out  32  saturating count of cycles with stall asserted.

## Operation
- State: cnt[1..31], each CNT_W bits; register 0 has no counter and is never busy.
- Hazard: hz_rs = id_uses_rs && id_rs_addr≠0 && cnt[id_rs_addr]≠0; hz_rt = the same for rt.
- stall = id_valid && !flush && (hz_rs || hz_rt). Flush overrides stall.
- issue = id_valid && !flush && !stall.
- Per-cycle update for each register r, in priority order:
  1. issue && id_dest_we && id_dest_addr=r≠0: cnt[r] ← (id_is_load ? LOAD_LAT : ALU_LAT).
  2. Else if wb_we && wb_addr=r: cnt[r] ← 0, an early release.
  3. Else if cnt[r]≠0: cnt[r] ← cnt[r]−1.
  4. Else hold at 0.
- A new issue overwrites an older pending count to the same register (WAW): the younger writer's latency is the one tracked.
- Stall state is implicit. RUN: stall=0. HOLD: stall=1. The transition HOLD→RUN happens on the cycle the blocking counter reaches 0 or wb releases it. The stall input is never latched; a stalled instruction re-evaluates every cycle.
- stall_cycles increments when stall=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset (rst_n low, asynchronous): all cnt ← 0, stall_cycles ← 0. Consequently busy_mask=0, and stall=0 with inputs idle. Reset mid-stall drops the hold immediately.
- Load issued at cycle t with LOAD_LAT=1: a dependent instruction in ID at t+1 sees cnt=1 and stalls for one cycle. It issues at t+2.
- A latency of 0 never sets busy; back-to-back dependents issue with no bubble.
- Issue and wb_we to the same register in the same cycle: the issue value wins.
- Source equals destination in the issuing instruction (e.g. addu $3,$3,$1): the hazard check uses pre-update counters, so the instruction issues when its own source is free.
- Flush while stalled: stall drops the same cycle, issue=0, counters keep decrementing, and stall_cycles does not increment.
- stall and issue are never both 1.

## Structure
- Shared package pipeline_pkg: REG_ADDR_W=5, NUM_REGS=32, OP_LW=6'h23, default ALU_LAT/LOAD_LAT constants.
- One sub-module, scoreboard_counter: a single CNT_W countdown with load/clear/decrement priority. It is instantiated 31 times by generate.
- Hazard/issue logic and the stall counter live in the top.

## Test plan
- Reset released, idle inputs → busy_mask=0, stall=0, stall_cycles=0; asserting rst_n low mid-stall zeroes all of them asynchronously.
- lw $5 issued at t, then addu $6,$5,$2 valid at t+1 → stall=1 at t+1, issue=1 at t+2, stall_cycles=1.
- ALU addu $7 at t, then subu using $7 at t+1 (ALU_LAT=0) → no stall, busy_mask[7] never set.
- lw $0 followed by a reader of $0 → no stall, busy_mask=0.
- lw $9 at t (LOAD_LAT=3 build) with wb_we,wb_addr=9 at t+1 → busy_mask[9] cleared at t+2, and the dependent issues at t+2, not t+4.
- Dependent stalled on $4 with flush=1 → stall=0 and issue=0 that cycle, cnt[4] still decrements; issue and wb_we to $4 in the same cycle → cnt[4]=LOAD_LAT afterwards.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the 5-stage MIPS pipeline decode/hazard logic.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned NUM_REGS     = 32;
    localparam logic [5:0]  OP_LW        = 6'h23;

    localparam int unsigned ALU_LAT_DEF  = 0;
    localparam int unsigned LOAD_LAT_DEF = 1;
    localparam int unsigned CNT_W_DEF    = 2;

endpackage

// File: rtl/decode_hazard_scoreboard_if.sv
// Decode-stage issue/writeback bundle between the decode block and the hazard scoreboard.
interface decode_hazard_scoreboard_if;
    import pipeline_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dest_addr;
    logic                  id_dest_we;
    logic                  id_is_load;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic                  flush;
    logic                  stall;
    logic                  issue;
    logic [NUM_REGS-1:0]   busy_mask;
    logic [31:0]           stall_cycles;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               id_dest_addr, id_dest_we, id_is_load, wb_we, wb_addr, flush,
        input  stall, issue, busy_mask, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               id_dest_addr, id_dest_we, id_is_load, wb_we, wb_addr, flush,
        output stall, issue, busy_mask, stall_cycles
    );

endinterface

// File: rtl/scoreboard_counter.sv
// One register's cycles-until-consumable countdown: load beats clear beats decrement.
module scoreboard_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/decode_hazard_scoreboard.sv
// Per-register scoreboard: holds decode while a source is in flight, grants issue otherwise.
module decode_hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int unsigned ALU_LAT  = ALU_LAT_DEF,
    parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    decode_hazard_scoreboard_if.slave  sb
);

    localparam logic [CNT_W-1:0] ALU_V  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_LAT);

    logic [NUM_REGS-1:0] busy;
    logic                hz_rs;
    logic                hz_rt;
    logic                stall;
    logic                issue;
    logic [CNT_W-1:0]    new_lat;
    logic [31:0]         stall_cnt_q;

    // Hazard check reads pre-update counters, so src==dest issues once its source is free.
    assign hz_rs   = sb.id_uses_rs && (sb.id_rs_addr != '0) && busy[sb.id_rs_addr];
    assign hz_rt   = sb.id_uses_rt && (sb.id_rt_addr != '0) && busy[sb.id_rt_addr];
    assign stall   = sb.id_valid && !sb.flush && (hz_rs || hz_rt);
    assign issue   = sb.id_valid && !sb.flush && !stall;
    assign new_lat = sb.id_is_load ? LOAD_V : ALU_V;

    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic ld;
        logic clr;

        assign ld  = issue && sb.id_dest_we && (sb.id_dest_addr == REG_ADDR_W'(r));
        assign clr = sb.wb_we && (sb.wb_addr == REG_ADDR_W'(r));

        scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (ld),
            .load_val (new_lat),
            .clear    (clr),
            .busy     (busy[r])
        );
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign sb.stall        = stall;
    assign sb.issue        = issue;
    assign sb.busy_mask    = busy;
    assign sb.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Directed bench for decode_hazard_scoreboard: LOAD_LAT=1 and LOAD_LAT=3 builds side by side.
module tb_decode_hazard_scoreboard;
    import pipeline_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    decode_hazard_scoreboard_if ifa ();
    decode_hazard_scoreboard_if ifb ();

    decode_hazard_scoreboard #(.ALU_LAT(0), .LOAD_LAT(1), .CNT_W(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (ifa)
    );

    decode_hazard_scoreboard #(.ALU_LAT(0), .LOAD_LAT(3), .CNT_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (ifb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic [4:0] dest,
                            input logic we, input logic ld);
        ifa.id_valid = v;    ifb.id_valid = v;
        ifa.id_rs_addr = rs; ifb.id_rs_addr = rs;
        ifa.id_rt_addr = rt; ifb.id_rt_addr = rt;
        ifa.id_uses_rs = urs; ifb.id_uses_rs = urs;
        ifa.id_uses_rt = urt; ifb.id_uses_rt = urt;
        ifa.id_dest_addr = dest; ifb.id_dest_addr = dest;
        ifa.id_dest_we = we; ifb.id_dest_we = we;
        ifa.id_is_load = ld; ifb.id_is_load = ld;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] addr);
        ifa.wb_we = we;     ifb.wb_we = we;
        ifa.wb_addr = addr; ifb.wb_addr = addr;
    endtask

    task automatic drive_flush(input logic f);
        ifa.flush = f; ifb.flush = f;
    endtask

    task automatic idle();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive_wb(1'b0, 5'd0);
        drive_flush(1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state with idle inputs
        do_reset();
        check("rst_busy", ifa.busy_mask, 32'h0);
        check("rst_stall", {31'd0, ifa.stall}, 32'd0);
        check("rst_stall_cycles", ifa.stall_cycles, 32'd0);

        // Load-use: lw $5 then addu $6,$5,$2
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        #1;
        check("lu_lw_issue", {31'd0, ifa.issue}, 32'd1);
        tick();
        drive_id(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        check("lu_stall", {31'd0, ifa.stall}, 32'd1);
        check("lu_no_issue", {31'd0, ifa.issue}, 32'd0);
        check("lu_busy", ifa.busy_mask, 32'h0000_0020);
        tick();
        check("lu_release_stall", {31'd0, ifa.stall}, 32'd0);
        check("lu_release_issue", {31'd0, ifa.issue}, 32'd1);
        check("lu_stall_cycles", ifa.stall_cycles, 32'd1);
        tick();
        check("lu_alu_dest_free", ifa.busy_mask, 32'h0);

        // ALU back-to-back with zero latency
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        check("alu_first_issue", {31'd0, ifa.issue}, 32'd1);
        tick();
        check("alu_busy_after", ifa.busy_mask, 32'h0);
        drive_id(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        check("alu_dep_stall", {31'd0, ifa.stall}, 32'd0);
        check("alu_dep_issue", {31'd0, ifa.issue}, 32'd1);

        // Load to $0 never marks busy
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        check("r0_busy", ifa.busy_mask, 32'h0);
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        #1;
        check("r0_stall", {31'd0, ifa.stall}, 32'd0);
        check("r0_issue", {31'd0, ifa.issue}, 32'd1);

        // Early release by writeback (LOAD_LAT=3 build)
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
        drive_wb(1'b1, 5'd9);
        #1;
        check("wb_pre_stall", {31'd0, ifb.stall}, 32'd1);
        check("wb_pre_busy", ifb.busy_mask, 32'h0000_0200);
        tick();
        drive_wb(1'b0, 5'd0);
        #1;
        check("wb_post_busy", ifb.busy_mask, 32'h0);
        check("wb_post_stall", {31'd0, ifb.stall}, 32'd0);
        check("wb_post_issue", {31'd0, ifb.issue}, 32'd1);

        // Flush while stalled: counters keep running, no stall counted
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
        drive_flush(1'b1);
        #1;
        check("fl_stall", {31'd0, ifb.stall}, 32'd0);
        check("fl_issue", {31'd0, ifb.issue}, 32'd0);
        check("fl_stall_a", {31'd0, ifa.stall}, 32'd0);
        tick();
        drive_flush(1'b0);
        #1;
        check("fl_no_count", ifb.stall_cycles, 32'd0);
        check("fl_restall", {31'd0, ifb.stall}, 32'd1);
        tick();
        tick();
        check("fl_issue_after", {31'd0, ifb.issue}, 32'd1);
        check("fl_stall_cycles", ifb.stall_cycles, 32'd2);

        // Issue and writeback to the same register: issue wins
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
        drive_wb(1'b1, 5'd4);
        #1;
        check("iw_issue", {31'd0, ifa.issue}, 32'd1);
        tick();
        idle();
        #1;
        check("iw_busy_a", ifa.busy_mask, 32'h0000_0010);
        check("iw_busy_b", ifb.busy_mask, 32'h0000_0010);
        tick();
        tick();
        check("iw_busy_b_last", ifb.busy_mask, 32'h0000_0010);
        tick();
        check("iw_busy_b_done", ifb.busy_mask, 32'h0);

        // Source equals destination: addu $3,$3,$1 after lw $3
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        #1;
        check("sd_stall", {31'd0, ifa.stall}, 32'd1);
        tick();
        check("sd_issue", {31'd0, ifa.issue}, 32'd1);
        tick();
        check("sd_busy", ifa.busy_mask, 32'h0);

        // Asynchronous reset in the middle of a stall
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        tick();
        check("ar_pre_stall", {31'd0, ifb.stall}, 32'd1);
        check("ar_pre_cycles", ifb.stall_cycles, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_stall", {31'd0, ifb.stall}, 32'd0);
        check("ar_busy", ifb.busy_mask, 32'h0);
        check("ar_cycles", ifb.stall_cycles, 32'd0);
        idle();
        tick();
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
